// File: rtl/serdes_flex.sv
// Lane-granular width converter: packs variable-count input beats into OUT_COUNT-lane output beats.
// Optional macro SERDES_FLEX_ZERO_PAD_EN forces output lanes at or above m_write_count to zero.
module serdes_flex #(
    parameter int IN_COUNT  = 10,
    parameter int OUT_COUNT = 10,
    parameter int OP_WIDTH  = 16
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [$clog2(IN_COUNT+1)-1:0]        count,
    input  logic                                 s_write_req,
    input  logic                                 s_write_flush,
    output logic                                 s_write_ready,
    input  logic [IN_COUNT*OP_WIDTH-1:0]         s_write_data,
    output logic                                 m_write_req,
    input  logic                                 m_write_ready,
    output logic [OUT_COUNT*OP_WIDTH-1:0]        m_write_data,
    output logic [$clog2(OUT_COUNT+1)-1:0]       m_write_count,
    output logic                                 m_write_last
);
    localparam int DEPTH = IN_COUNT + OUT_COUNT;
    localparam int FW    = $clog2(DEPTH + 1);
    localparam int CW    = $clog2(IN_COUNT + 1);
    localparam int OCW   = $clog2(OUT_COUNT + 1);

    logic [FW-1:0] r_fill;
    logic          r_flush;
    logic          r_ready;

    logic [DEPTH-1:0][OP_WIDTH-1:0]    w_buf;
    logic [IN_COUNT-1:0][OP_WIDTH-1:0] w_in_lane;
    logic [FW-1:0] w_cnt_in, w_lanes_in, w_lanes_out, w_fill_mid, w_fill_next, w_out_cnt;
    logic          w_in_fire, w_flush_acc, w_out_req, w_out_last, w_out_fire, w_flush_next;

    assign w_in_lane   = s_write_data;
    assign w_in_fire   = s_write_req && r_ready;
    assign w_flush_acc = s_write_flush && r_ready;
    assign w_cnt_in    = (count > CW'(IN_COUNT)) ? FW'(IN_COUNT) : FW'(count);
    assign w_lanes_in  = w_in_fire ? w_cnt_in : '0;

    // Lane 0 of the buffer is always the oldest operand, so an output beat is simply lanes 0..OUT_COUNT-1.
    always_comb begin
        w_out_req  = 1'b0;
        w_out_cnt  = '0;
        w_out_last = 1'b0;
        if (r_fill >= FW'(OUT_COUNT)) begin
            w_out_req  = 1'b1;
            w_out_cnt  = FW'(OUT_COUNT);
            w_out_last = r_flush && (r_fill == FW'(OUT_COUNT));
        end else if (r_flush && (r_fill != '0)) begin
            w_out_req  = 1'b1;
            w_out_cnt  = r_fill;
            w_out_last = 1'b1;
        end
    end

    assign w_out_fire  = w_out_req && m_write_ready;
    assign w_lanes_out = w_out_fire ? w_out_cnt : '0;
    assign w_fill_mid  = r_fill - w_lanes_out;
    assign w_fill_next = w_fill_mid + w_lanes_in;

    // A newly accepted flush wins; it is applied to the combined contents from the next cycle on.
    always_comb begin
        w_flush_next = r_flush;
        if ((w_out_fire && w_out_last) || (r_flush && (r_fill == '0)))
            w_flush_next = 1'b0;
        if (w_flush_acc)
            w_flush_next = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fill  <= '0;
            r_flush <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_fill  <= w_fill_next;
            r_flush <= w_flush_next;
            r_ready <= (w_fill_next <= FW'(OUT_COUNT)) && !w_flush_next;
        end
    end

    // Each buffer lane first shifts down by the departing lane count, then may capture an arriving operand.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_lane
        logic [OP_WIDTH-1:0] r_lane;
        logic [OP_WIDTH-1:0] w_lane_next;

        always_comb begin
            w_lane_next = r_lane;
            for (int k = 1; k <= OUT_COUNT; k++) begin
                if ((gi + k < DEPTH) && (w_lanes_out == FW'(k)))
                    w_lane_next = w_buf[(gi + k) % DEPTH];
            end
            for (int j = 0; j < IN_COUNT; j++) begin
                if ((FW'(j) < w_lanes_in) && (w_fill_mid + FW'(j) == FW'(gi)))
                    w_lane_next = w_in_lane[j];
            end
        end

        always_ff @(posedge clk) begin
            if (reset)
                r_lane <= '0;
            else
                r_lane <= w_lane_next;
        end

        assign w_buf[gi] = r_lane;
    end

    for (genvar gi = 0; gi < OUT_COUNT; gi++) begin : g_out
        logic w_pad;
`ifdef SERDES_FLEX_ZERO_PAD_EN
        assign w_pad = (FW'(gi) >= w_out_cnt);
`else
        assign w_pad = 1'b0;
`endif
        assign m_write_data[gi*OP_WIDTH +: OP_WIDTH] = (reset || w_pad) ? '0 : w_buf[gi];
    end

    assign s_write_ready = r_ready;
    assign m_write_req   = w_out_req && !reset;
    assign m_write_count = reset ? '0 : OCW'(w_out_cnt);
    assign m_write_last  = w_out_last && !reset;
endmodule

// File: tb/tb_serdes_flex.sv
// Scoreboard bench for serdes_flex: three instances (10->10, 4->10, 10->4 lanes) driven by directed vectors.
module tb_serdes_flex;
    typedef struct {
        logic [159:0] data;
        int           cnt;
        bit           last;
    } beat_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   beats_seen [3];

    logic [159:0] s_data  [3];
    logic [3:0]   cnt     [3];
    logic         s_req   [3];
    logic         s_flush [3];
    logic         m_ready [3];

    logic         s_rdy  [3];
    logic         m_req  [3];
    logic [159:0] m_data [3];
    logic [3:0]   m_cnt  [3];
    logic         m_last [3];

    logic [15:0] mq    [3][$];
    beat_t       exp_q [3][$];

    logic         u0_rdy, u1_rdy, u2_rdy, u0_req, u1_req, u2_req, u0_last, u1_last, u2_last;
    logic [159:0] u0_data, u1_data;
    logic [63:0]  u2_data;
    logic [3:0]   u0_cnt, u1_cnt;
    logic [2:0]   u2_cnt;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    serdes_flex #(.IN_COUNT(10), .OUT_COUNT(10), .OP_WIDTH(16)) u0 (
        .clk(clk), .reset(reset), .count(cnt[0]), .s_write_req(s_req[0]),
        .s_write_flush(s_flush[0]), .s_write_ready(u0_rdy), .s_write_data(s_data[0]),
        .m_write_req(u0_req), .m_write_ready(m_ready[0]), .m_write_data(u0_data),
        .m_write_count(u0_cnt), .m_write_last(u0_last));

    serdes_flex #(.IN_COUNT(4), .OUT_COUNT(10), .OP_WIDTH(16)) u1 (
        .clk(clk), .reset(reset), .count(cnt[1][2:0]), .s_write_req(s_req[1]),
        .s_write_flush(s_flush[1]), .s_write_ready(u1_rdy), .s_write_data(s_data[1][63:0]),
        .m_write_req(u1_req), .m_write_ready(m_ready[1]), .m_write_data(u1_data),
        .m_write_count(u1_cnt), .m_write_last(u1_last));

    serdes_flex #(.IN_COUNT(10), .OUT_COUNT(4), .OP_WIDTH(16)) u2 (
        .clk(clk), .reset(reset), .count(cnt[2]), .s_write_req(s_req[2]),
        .s_write_flush(s_flush[2]), .s_write_ready(u2_rdy), .s_write_data(s_data[2]),
        .m_write_req(u2_req), .m_write_ready(m_ready[2]), .m_write_data(u2_data),
        .m_write_count(u2_cnt), .m_write_last(u2_last));

    assign s_rdy[0]  = u0_rdy;             assign s_rdy[1]  = u1_rdy;             assign s_rdy[2]  = u2_rdy;
    assign m_req[0]  = u0_req;             assign m_req[1]  = u1_req;             assign m_req[2]  = u2_req;
    assign m_last[0] = u0_last;            assign m_last[1] = u1_last;            assign m_last[2] = u2_last;
    assign m_data[0] = u0_data;            assign m_data[1] = u1_data;            assign m_data[2] = {96'b0, u2_data};
    assign m_cnt[0]  = u0_cnt;             assign m_cnt[1]  = u1_cnt;             assign m_cnt[2]  = {1'b0, u2_cnt};

    function automatic int inc(input int u);
        return (u == 1) ? 4 : 10;
    endfunction

    function automatic int outc(input int u);
        return (u == 2) ? 4 : 10;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_beat(input int u, input int n, input bit last);
        beat_t b;
        b.data = '0;
        b.cnt  = n;
        b.last = last;
        for (int i = 0; i < n; i++) b.data[i*16 +: 16] = mq[u].pop_front();
        exp_q[u].push_back(b);
    endtask

    // Drive one input beat (or a bare flush when req=0), wait for acceptance, then update the lane model.
    task automatic send(input int u, input bit req, input int n, input int base, input bit fl);
        int  nin;
        int  w;
        bit  produced;
        beat_t b;
        nin = (n > inc(u)) ? inc(u) : n;
        s_req[u]   = req;
        s_flush[u] = fl;
        cnt[u]     = 4'(n);
        s_data[u]  = '0;
        for (int i = 0; i < inc(u); i++) s_data[u][i*16 +: 16] = 16'(base + i);
        w = 0;
        while (!s_rdy[u] && w < 300) begin
            tick(1);
            w++;
        end
        if (!s_rdy[u]) begin
            total++;
            bad++;
            $display("FAIL accept_timeout u%0d: s_write_ready=%0d after %0d cycles, need 1", u, s_rdy[u], w);
        end else begin
            tick(1);
            if (req) for (int i = 0; i < nin; i++) mq[u].push_back(16'(base + i));
            produced = 1'b0;
            while (mq[u].size() >= outc(u)) begin
                push_beat(u, outc(u), 1'b0);
                produced = 1'b1;
            end
            if (fl) begin
                if (mq[u].size() > 0) begin
                    push_beat(u, mq[u].size(), 1'b1);
                end else if (produced) begin
                    b = exp_q[u].pop_back();
                    b.last = 1'b1;
                    exp_q[u].push_back(b);
                end
            end
        end
        s_req[u]   = 1'b0;
        s_flush[u] = 1'b0;
    endtask

    task automatic check(input string name, input int got, input int need);
        total++;
        if (got != need) begin
            bad++;
            $display("FAIL %s: got %0d, need %0d", name, got, need);
        end
    endtask

    task automatic check_reset_outputs(input int u);
        total++;
        if (m_req[u] !== 1'b0 || m_cnt[u] !== 4'd0 || m_last[u] !== 1'b0 || m_data[u] !== '0 || s_rdy[u] !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs u%0d: got req=%0d cnt=%0d last=%0d rdy=%0d data=%h, need all zero",
                     u, m_req[u], m_cnt[u], m_last[u], s_rdy[u], m_data[u]);
        end
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_mon
        bit           hold_v = 1'b0;
        logic [159:0] hold_d;
        logic [3:0]   hold_c;
        logic         hold_l;
        beat_t        e;
        logic [159:0] mask;

        always @(negedge clk) begin
            if (reset) begin
                hold_v = 1'b0;
            end else begin
                if (hold_v) begin
                    total++;
                    if (m_req[gi] !== 1'b1 || m_data[gi] !== hold_d || m_cnt[gi] !== hold_c || m_last[gi] !== hold_l) begin
                        bad++;
                        $display("FAIL hold u%0d: got req=%0d cnt=%0d last=%0d data=%h, need req=1 cnt=%0d last=%0d data=%h",
                                 gi, m_req[gi], m_cnt[gi], m_last[gi], m_data[gi], hold_c, hold_l, hold_d);
                    end
                end
                hold_v = m_req[gi] && !m_ready[gi];
                hold_d = m_data[gi];
                hold_c = m_cnt[gi];
                hold_l = m_last[gi];
                if (m_req[gi] && m_ready[gi]) begin
                    beats_seen[gi]++;
                    total++;
                    if (exp_q[gi].size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_beat u%0d: got cnt=%0d last=%0d data=%h, need no beat",
                                 gi, m_cnt[gi], m_last[gi], m_data[gi]);
                    end else begin
                        e = exp_q[gi].pop_front();
                        mask = '0;
`ifdef SERDES_FLEX_ZERO_PAD_EN
                        for (int l = 0; l < outc(gi); l++) mask[l*16 +: 16] = 16'hffff;
`else
                        for (int l = 0; l < e.cnt; l++) mask[l*16 +: 16] = 16'hffff;
`endif
                        if (int'(m_cnt[gi]) != e.cnt || m_last[gi] !== e.last || (m_data[gi] & mask) !== (e.data & mask)) begin
                            bad++;
                            $display("FAIL beat u%0d: got cnt=%0d last=%0d data=%h, need cnt=%0d last=%0d data=%h",
                                     gi, m_cnt[gi], m_last[gi], m_data[gi] & mask, e.cnt, e.last, e.data & mask);
                        end else begin
                            $display("beat u%0d: cnt=%0d last=%0d lane0=%h", gi, m_cnt[gi], m_last[gi], m_data[gi][15:0]);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int b0;
        for (int u = 0; u < 3; u++) begin
            s_req[u] = 1'b0; s_flush[u] = 1'b0; cnt[u] = '0; s_data[u] = '0; m_ready[u] = 1'b1;
            beats_seen[u] = 0;
        end
        reset = 1'b1;
        tick(3);
        for (int u = 0; u < 3; u++) check_reset_outputs(u);
        reset = 1'b0;
        tick(1);
        for (int u = 0; u < 3; u++) check($sformatf("ready_after_reset_u%0d", u), int'(s_rdy[u]), 1);

        // Equal widths: three full beats, one accepted and one emitted per cycle.
        c0 = cyc;
        b0 = beats_seen[0];
        for (int k = 0; k < 3; k++) send(0, 1'b1, 10, 'h1000 + 16 * k, 1'b0);
        check("tput_in_cycles", cyc - c0, 3);
        tick(1);
        check("tput_out_beats", beats_seen[0] - b0, 3);

        // 4 -> 10: twenty lanes form two full beats, then a flush on the drained buffer.
        for (int k = 0; k < 5; k++) send(1, 1'b1, 4, 'h2000 + 4 * k, 1'b0);
        tick(10);
        b0 = beats_seen[1];
        send(1, 1'b0, 0, 0, 1'b1);
        tick(1);
        check("empty_flush_ready", int'(s_rdy[1]), 1);
        tick(3);
        check("empty_flush_no_beat", beats_seen[1] - b0, 0);

        // 10 -> 4: partial flush tail, exact-multiple flush, and clamped count.
        send(2, 1'b1, 9, 'h3000, 1'b1);
        send(2, 1'b1, 8, 'h3100, 1'b1);
        send(2, 1'b1, 15, 'h3200, 1'b1);
        tick(12);

        // Output stall for 20 cycles while count=7 beats keep arriving.
        m_ready[0] = 1'b0;
        fork
            begin
                for (int k = 0; k < 10; k++) send(0, 1'b1, 7, 'h4000 + 7 * k, 1'b0);
            end
            begin
                tick(20);
                check("stall_ready_low", int'(s_rdy[0]), 0);
                m_ready[0] = 1'b1;
            end
        join
        tick(10);

        // Reset with six lanes buffered, then a fresh stream must carry none of them.
        send(0, 1'b1, 6, 'h5000, 1'b0);
        tick(3);
        check("pre_reset_no_beat", int'(m_req[0]), 0);
        reset = 1'b1;
        tick(1);
        check_reset_outputs(0);
        for (int u = 0; u < 3; u++) begin
            mq[u].delete();
            exp_q[u].delete();
        end
        reset = 1'b0;
        tick(1);
        check("ready_after_mid_reset", int'(s_rdy[0]), 1);
        send(0, 1'b1, 10, 'h6000, 1'b0);
        send(0, 1'b1, 10, 'h6100, 1'b0);

        for (int w = 0; w < 100; w++) begin
            if (exp_q[0].size() == 0 && exp_q[1].size() == 0 && exp_q[2].size() == 0) break;
            tick(1);
        end
        for (int u = 0; u < 3; u++) check($sformatf("drained_u%0d", u), exp_q[u].size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serdes_flex.md
SERDES_FLEX -- requirements
Module: serdes_flex

Interface
REQ-001 The block SHALL have parameter IN_COUNT, default 10, meaning the number of operand lanes per input beat (IN_WIDTH = IN_COUNT*OP_WIDTH).
REQ-002 The block SHALL have parameter OUT_COUNT, default 10, meaning the number of operand lanes per output beat (OUT_WIDTH = OUT_COUNT*OP_WIDTH); any ratio to IN_COUNT is legal.
REQ-003 The block SHALL have parameter OP_WIDTH, default 16, meaning the operand width in bits.
REQ-004 The block SHALL have port clk  input  1  system clock; all logic on the rising edge.
REQ-005 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have port count  input  C_LOG_2(IN_COUNT+1)  number of valid low lanes in s_write_data, range 0..IN_COUNT.
REQ-007 The block SHALL have port s_write_req  input  1  input beat valid.
REQ-008 The block SHALL have port s_write_flush  input  1  end-of-stream marker, sampled when s_write_ready=1.
REQ-009 The block SHALL have port s_write_ready  output  1  block can accept an input beat.
REQ-010 The block SHALL have port s_write_data  input  IN_WIDTH  input operands; lane 0 at LSBs.
REQ-011 The block SHALL have port m_write_req  output  1  output beat valid.
REQ-012 The block SHALL have port m_write_ready  input  1  downstream accepts an output beat.
REQ-013 The block SHALL have port m_write_data  output  OUT_WIDTH  output operands; lane 0 at LSBs.
REQ-014 The block SHALL have port m_write_count  output  C_LOG_2(OUT_COUNT+1)  number of valid low lanes in m_write_data.
REQ-015 The block SHALL have port m_write_last  output  1  this beat closes a flushed stream.

Function
REQ-016 The block SHALL buffer operands in an internal FIFO of IN_COUNT+OUT_COUNT lanes, with occupancy fill (0..IN_COUNT+OUT_COUNT).
REQ-017 An input transfer SHALL occur when s_write_req && s_write_ready; the block SHALL append lanes 0..count-1 in lane order and ignore the lanes above count.
REQ-018 s_write_ready SHALL be 1 iff fill <= OUT_COUNT and no flush is pending; it is a registered output.
REQ-019 An output transfer SHALL occur when m_write_req && m_write_ready; m_write_data, m_write_count and m_write_last SHALL hold stable while m_write_req=1 and m_write_ready=0.
REQ-020 The block SHALL assert m_write_req with m_write_count=OUT_COUNT, m_write_last=0 when fill >= OUT_COUNT.
REQ-021 When a flush is pending and 0 < fill < OUT_COUNT, the block SHALL emit one beat with m_write_count=fill, m_write_last=1, then clear the flush.
REQ-022 If the flush drains exactly at a full beat (fill==OUT_COUNT), that beat SHALL carry m_write_last=1.
REQ-023 A flush with fill==0 and no pending data SHALL produce no output beat and SHALL clear in one cycle.
REQ-024 Simultaneous s_write_req and s_write_flush SHALL append the data first, then apply the flush to the combined contents.
REQ-025 Minimum latency from input transfer to m_write_req SHALL be 1 cycle; at IN_COUNT==OUT_COUNT with count=IN_COUNT, sustained throughput SHALL be one beat per cycle.
REQ-026 A simultaneous input and output transfer SHALL update fill by +count-lanes_out in that cycle.
REQ-027 count > IN_COUNT SHALL be clamped to IN_COUNT.

Reset
REQ-028 While reset=1, fill SHALL be 0, flush pending SHALL clear, m_write_req=0, m_write_count=0, m_write_last=0, m_write_data=0 and s_write_ready=0.
REQ-029 s_write_ready SHALL rise on the first cycle after reset deasserts; a reset during a stalled output SHALL drop all buffered lanes without emitting them.

Configuration
REQ-030 With macro SERDES_FLEX_ZERO_PAD_EN defined, lanes at or above m_write_count SHALL be driven to 0; without it, those lanes SHALL be don't-care (stale buffer contents).

Verification
REQ-031 IN=OUT=10: three beats with count=10 and m_write_ready=1 -> three output beats, identical data, count=10, last=0, one per cycle.
REQ-032 IN=4, OUT=10: five beats with count=4, then flush -> beats of 10 and 10 lanes, last=0, in order.
REQ-033 IN=10, OUT=4: one beat with count=9 plus flush -> beats of 4, 4, 1 lanes; the last beat has last=1 and pad lanes are 0 under SERDES_FLEX_ZERO_PAD_EN.
REQ-034 m_write_ready held at 0 for 20 cycles during a stream of count=7 beats -> s_write_ready drops when fill > OUT_COUNT, output held stable, and no lane is lost or duplicated.
REQ-035 A flush with an empty buffer -> no m_write_req; the flush also clears and s_write_ready returns to 1 in the next cycle.
REQ-036 Reset asserted mid-stream with fill=6 -> all outputs are 0 the next cycle, and the following stream is output without residue from the first.
